// File: rtl/game_pkg.sv
// Shared types and constants for the player movement controller: directions,
// movement states, USB keycodes and small decode helpers.
package game_pkg;

   typedef enum logic [1:0] {
      DIR_DOWN  = 2'd0,
      DIR_UP    = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TURN,
      ST_STEP,
      ST_BUMP
   } move_state_t;

   localparam logic [7:0] KEY_W     = 8'h1A;
   localparam logic [7:0] KEY_A     = 8'h04;
   localparam logic [7:0] KEY_S     = 8'h16;
   localparam logic [7:0] KEY_D     = 8'h07;
   localparam logic [7:0] KEY_ENTER = 8'h28;
   localparam logic [7:0] KEY_ESC   = 8'h29;

   typedef struct packed {
      logic valid;
      dir_t dir;
   } key_t;

   function automatic key_t decode_key(input logic [7:0] code);
      key_t k;
      k.valid = 1'b1;
      k.dir   = DIR_DOWN;
      case (code)
         KEY_S:   k.dir = DIR_DOWN;
         KEY_W:   k.dir = DIR_UP;
         KEY_A:   k.dir = DIR_LEFT;
         KEY_D:   k.dir = DIR_RIGHT;
         default: k.valid = 1'b0;
      endcase
      return k;
   endfunction

   // Walk cycle 0,1,2,1 indexed by a free-running 2-bit phase.
   function automatic logic [1:0] phase_to_frame(input logic [1:0] phase);
      return (phase == 2'd2) ? 2'd2 : {1'b0, phase[0]};
   endfunction

endpackage

// File: rtl/char_move_ctrl_if.sv
// Input/output bundle between the keycode/collision path and the movement
// controller; the controller uses the slave side.
interface char_move_ctrl_if #(
   parameter int TILE_PX = 16,
   parameter int MAP_W   = 64,
   parameter int MAP_H   = 64
) ();
   import game_pkg::*;

   logic                       frame_tick;
   logic                       enable;
   logic [7:0]                 keycode;
   logic                       run;
   logic [3:0]                 blocked;

   logic                       moving;
   dir_t                       direction;
   logic [1:0]                 anim_frame;
   logic [$clog2(TILE_PX)-1:0] px_offset;
   logic [$clog2(MAP_W)-1:0]   tile_x;
   logic [$clog2(MAP_H)-1:0]   tile_y;
   logic                       step_done;

   modport master (
      output frame_tick, enable, keycode, run, blocked,
      input  moving, direction, anim_frame, px_offset, tile_x, tile_y, step_done
   );

   modport slave (
      input  frame_tick, enable, keycode, run, blocked,
      output moving, direction, anim_frame, px_offset, tile_x, tile_y, step_done
   );
endinterface

// File: rtl/char_move_ctrl_anim_seq.sv
// Walk-cycle animation: phase counter advancing every FRAME_TICKS ticks
// (half that when running), mapped to frames 0,1,2,1.
module anim_seq
   import game_pkg::*;
#(
   parameter int FRAME_TICKS = 10
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       tick,
   input  logic       active,
   input  logic       run_mode,
   output logic [1:0] frame
);
   localparam int SUBW = $clog2(FRAME_TICKS);
   localparam logic [SUBW-1:0] WALK_LAST = SUBW'(FRAME_TICKS - 1);
   localparam logic [SUBW-1:0] RUN_LAST  = SUBW'(FRAME_TICKS / 2 - 1);

   logic [SUBW-1:0] sub_q;
   logic [SUBW-1:0] last;
   logic [1:0]      phase_q;

   assign last = run_mode ? RUN_LAST : WALK_LAST;

   // >= so a walk-to-run switch mid-phase cannot overshoot the shorter phase.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sub_q   <= '0;
         phase_q <= '0;
         frame   <= '0;
      end else if (tick) begin
         if (!active) begin
            sub_q   <= '0;
            phase_q <= '0;
            frame   <= '0;
         end else if (sub_q >= last) begin
            sub_q   <= '0;
            phase_q <= phase_q + 2'd1;
            frame   <= phase_to_frame(phase_q + 2'd1);
         end else begin
            sub_q <= sub_q + SUBW'(1);
         end
      end
   end
endmodule

// File: rtl/char_move_ctrl.sv
// Tile-step movement controller: WASD to whole-tile moves with turn-in-place,
// walk/run speed, collision bump and map-edge clamping; advances once per frame.
module char_move_ctrl
   import game_pkg::*;
#(
   parameter int TILE_PX     = 16,
   parameter int WALK_STEP   = 1,
   parameter int RUN_STEP    = 2,
   parameter int FRAME_TICKS = 10,
   parameter int TURN_TICKS  = 4,
   parameter int BUMP_TICKS  = 16,
   parameter int MAP_W       = 64,
   parameter int MAP_H       = 64,
   parameter int START_X     = 0,
   parameter int START_Y     = 0
) (
   input logic             Clk,
   input logic             Reset,
   char_move_ctrl_if.slave bus
);
   localparam int PXW  = $clog2(TILE_PX);
   localparam int SW   = PXW + 1;
   localparam int XW   = $clog2(MAP_W);
   localparam int YW   = $clog2(MAP_H);
   localparam int CMAX = (TURN_TICKS > BUMP_TICKS) ? TURN_TICKS : BUMP_TICKS;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [SW-1:0] TILE_S    = SW'(TILE_PX);
   localparam logic [SW-1:0] WALK_S    = SW'(WALK_STEP);
   localparam logic [SW-1:0] RUN_S     = SW'(RUN_STEP);
   localparam logic [CW-1:0] TURN_LAST = CW'(TURN_TICKS - 1);
   localparam logic [CW-1:0] BUMP_LAST = CW'(BUMP_TICKS - 1);
   localparam logic [XW-1:0] X_MAX     = XW'(MAP_W - 1);
   localparam logic [YW-1:0] Y_MAX     = YW'(MAP_H - 1);
   localparam logic [XW-1:0] X_START   = XW'(START_X);
   localparam logic [YW-1:0] Y_START   = YW'(START_Y);

   if (TILE_PX % WALK_STEP != 0) begin : g_bad_walk
      $error("TILE_PX must be a multiple of WALK_STEP");
   end
   if (TILE_PX % RUN_STEP != 0) begin : g_bad_run
      $error("TILE_PX must be a multiple of RUN_STEP");
   end
   if (FRAME_TICKS < 2) begin : g_bad_frame
      $error("FRAME_TICKS must be at least 2");
   end

   move_state_t    state_q, state_n;
   dir_t           dir_q, dir_n;
   logic [PXW-1:0] px_q, px_n;
   logic [XW-1:0]  tx_q, tx_n;
   logic [YW-1:0]  ty_q, ty_n;
   logic [SW-1:0]  spd_q, spd_n;
   logic           run_q, run_n;
   logic [CW-1:0]  cnt_q, cnt_n;
   logic           done_q, done_n;

   key_t           key;
   logic           tick;
   logic [SW-1:0]  px_sum;
   logic [XW-1:0]  tx_step;
   logic [YW-1:0]  ty_step;
   logic           here_blocked;
   logic           next_blocked;
   logic           anim_active;
   logic [1:0]     anim_frame;

   function automatic logic at_edge(input dir_t d, input logic [XW-1:0] x,
                                    input logic [YW-1:0] y);
      logic e;
      case (d)
         DIR_DOWN:  e = (y == Y_MAX);
         DIR_UP:    e = (y == '0);
         DIR_LEFT:  e = (x == '0);
         default:   e = (x == X_MAX);
      endcase
      return e;
   endfunction

   assign key    = decode_key(bus.keycode);
   assign tick   = bus.frame_tick & bus.enable;
   assign px_sum = {1'b0, px_q} + spd_q;

   // Tile one step ahead in the facing direction; becomes the new tile on step completion.
   always_comb begin
      tx_step = tx_q;
      ty_step = ty_q;
      case (dir_q)
         DIR_DOWN:  ty_step = ty_q + YW'(1);
         DIR_UP:    ty_step = ty_q - YW'(1);
         DIR_LEFT:  tx_step = tx_q - XW'(1);
         default:   tx_step = tx_q + XW'(1);
      endcase
   end

   assign here_blocked = bus.blocked[dir_q] | at_edge(dir_q, tx_q, ty_q);
   assign next_blocked = bus.blocked[dir_q] | at_edge(dir_q, tx_step, ty_step);

   always_comb begin
      state_n = state_q;
      dir_n   = dir_q;
      px_n    = px_q;
      tx_n    = tx_q;
      ty_n    = ty_q;
      spd_n   = spd_q;
      run_n   = run_q;
      cnt_n   = cnt_q;
      done_n  = 1'b0;
      if (tick) begin
         case (state_q)
            ST_IDLE: begin
               if (key.valid) begin
                  if (key.dir != dir_q) begin
                     dir_n   = key.dir;
                     state_n = ST_TURN;
                     cnt_n   = '0;
                  end else if (here_blocked) begin
                     state_n = ST_BUMP;
                     cnt_n   = '0;
                     run_n   = bus.run;
                  end else begin
                     state_n = ST_STEP;
                     px_n    = '0;
                     spd_n   = bus.run ? RUN_S : WALK_S;
                     run_n   = bus.run;
                  end
               end
            end
            ST_TURN: begin
               if (cnt_q == TURN_LAST) begin
                  state_n = ST_IDLE;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt_q + CW'(1);
               end
            end
            ST_BUMP: begin
               if (cnt_q == BUMP_LAST) begin
                  state_n = ST_IDLE;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt_q + CW'(1);
               end
            end
            default: begin
               if (px_sum >= TILE_S) begin
                  px_n   = '0;
                  tx_n   = tx_step;
                  ty_n   = ty_step;
                  done_n = 1'b1;
                  if (key.valid && key.dir == dir_q && !next_blocked) begin
                     spd_n = bus.run ? RUN_S : WALK_S;
                     run_n = bus.run;
                  end else begin
                     state_n = ST_IDLE;
                  end
               end else begin
                  px_n = px_sum[PXW-1:0];
               end
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         dir_q   <= DIR_UP;
         px_q    <= '0;
         tx_q    <= X_START;
         ty_q    <= Y_START;
         spd_q   <= '0;
         run_q   <= 1'b0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         dir_q   <= dir_n;
         px_q    <= px_n;
         tx_q    <= tx_n;
         ty_q    <= ty_n;
         spd_q   <= spd_n;
         run_q   <= run_n;
         cnt_q   <= cnt_n;
         done_q  <= done_n;
      end
   end

   // Animation clears on the entry and exit ticks, runs on through step continuations.
   assign anim_active = (state_q == ST_STEP || state_q == ST_BUMP) &&
                        (state_n == ST_STEP || state_n == ST_BUMP);

   anim_seq #(
      .FRAME_TICKS(FRAME_TICKS)
   ) u_anim (
      .Clk      (Clk),
      .Reset    (Reset),
      .tick     (tick),
      .active   (anim_active),
      .run_mode (run_q),
      .frame    (anim_frame)
   );

   assign bus.moving     = (state_q == ST_STEP);
   assign bus.direction  = dir_q;
   assign bus.anim_frame = anim_frame;
   assign bus.px_offset  = px_q;
   assign bus.tile_x     = tx_q;
   assign bus.tile_y     = ty_q;
   assign bus.step_done  = done_q;
endmodule

// File: doc/char_move_ctrl.md
# char_move_ctrl

Parametrised tile-step movement controller for the player sprite in the main-game state. Converts WASD keycodes into whole-tile moves with turn-in-place, walk/run speeds, collision bump and map-edge clamping. Outputs facing, sub-tile pixel offset, tile coordinates and a 4-phase walk-cycle frame. Sits between the USB keycode path and the sprite/map renderer, advancing once per video frame.

## Interface
- TILE_PX, 16: tile edge in pixels; power of two.
- WALK_STEP, 1: pixels per frame tick while walking.
- RUN_STEP, 2: pixels per frame tick while running.
- FRAME_TICKS, 10: ticks per animation phase when walking; halved when running.
- TURN_TICKS, 4: ticks spent turning in place.
- BUMP_TICKS, 16: ticks spent in blocked-bump animation.
- MAP_W, 64 / MAP_H, 64: map size in tiles.
- START_X, 0 / START_Y, 0: reset tile position.
- Clk  in  1  system clock.
- Reset  in  1  reset Reset, synchronous, active-high.
- frame_tick  in  1  one-Clk pulse per frame (VS edge, synchronised upstream).
- enable  in  1  high only in the main-game state.
- keycode  in  8  current USB keycode.
- run  in  1  run button held.
- blocked  in  4  per-direction collision from the map lookup, indexed by dir_t.
- moving  out  1  high in STEP.
- direction  out  2  facing: 0 down, 1 up, 2 left, 3 right.
- anim_frame  out  2  walk-cycle frame, 0/1/2.
- px_offset  out  $clog2(TILE_PX)  sub-tile offset along direction.
- tile_x / tile_y  out  $clog2(MAP_W) / $clog2(MAP_H)  current tile.
- step_done  out  1  one-Clk pulse when a tile move completes.

## Operation
- States: IDLE, TURN, STEP, BUMP. All transitions and counter updates occur only on Clk edges with frame_tick && enable. With enable low, all state is frozen, including mid-step.
- Key decode: S→0, W→1, A→2, D→3. Any other code means no key.
- IDLE, key d != direction: set direction=d and enter TURN for TURN_TICKS ticks, then IDLE. No movement occurs.
- IDLE, key d == direction:
  - Blocked (blocked[d], or the next tile lies outside 0..MAP_W-1 / 0..MAP_H-1): enter BUMP for BUMP_TICKS ticks, then IDLE. moving=0; anim_frame animates.
  - Otherwise: enter STEP. Latch spd = run ? RUN_STEP : WALK_STEP for the whole step.
- STEP: px_offset += spd each tick. When the sum reaches TILE_PX: set px_offset=0, update the tile coordinate by ±1, pulse step_done. Then:
  - Same key held and the next tile is not blocked: stay in STEP, re-latch spd, and keep the animation continuous.
  - Otherwise: go to IDLE.
- A direction change requested mid-step is ignored until the step completes.
- Animation counter runs in STEP and BUMP and is reset to 0 in IDLE/TURN. Phase sequence is 0,1,2,1 (period 4×FRAME_TICKS, or 4×(FRAME_TICKS/2) in run) and wraps.
- Reset values: state IDLE, direction 1, tile START_X/START_Y, px_offset 0, moving 0, anim_frame 0, step_done 0, all counters 0.
- Reset asserted mid-step discards the step with no partial coordinate change.

## Timing
- All outputs are registered and valid one Clk after the qualifying tick edge.
- Walk step takes TILE_PX/WALK_STEP ticks (16). Run step takes TILE_PX/RUN_STEP ticks (8).
- step_done is high for exactly one Clk, coincident with the tile update.
- blocked is sampled on the tick that decides STEP or BUMP, and again on the continuation tick.
- Elaboration assertions: TILE_PX % WALK_STEP == 0, TILE_PX % RUN_STEP == 0, FRAME_TICKS ≥ 2.

## Structure
- game_pkg: dir_t enum, key constants (KEY_W 8'h1A, KEY_A 8'h04, KEY_S 8'h16, KEY_D 8'h07, KEY_ENTER 8'h28, KEY_ESC 8'h29), move_state_t.
- Sub-module anim_seq: phase counter plus 0,1,2,1 mapper. Inputs: run_mode, active, tick. Output: frame.

## Test plan
- Reset, then tick with KEY_W → direction=1; 16 ticks later tile_y-1, step_done one pulse, px_offset back to 0.
- Facing up, hold KEY_D for 4 ticks → direction=3, moving=0, tile unchanged; continued hold then starts a STEP.
- run=1, KEY_S held across 2 tiles → 8 ticks per tile, no IDLE gap between tiles, anim_frame sequence 0,1,2,1 at 5-tick phases.
- blocked[2]=1, facing left, KEY_A held → BUMP for 16 ticks, tile_x unchanged, moving=0.
- At tile_x=0, facing left, KEY_A → BUMP, no underflow; at tile_x=MAP_W-1, facing right, KEY_D → BUMP, no overflow.
- enable dropped at px_offset=6 for 20 ticks → outputs frozen; after re-enable, the step completes in 10 more ticks. Reset mid-step → START position, px_offset 0.
